byte_assembly_register: RTL and testbench
=========================================

// Module: byte_assembly_register
// PURPOSE
//  Parametrised successor of the 8-bit-in/32-bit-out data register: NBYTES lanes of BYTE_W bits.
//  Keeps single-cycle load/shift modes; adds a handshaked burst mode that assembles 1..NBYTES
//  bytes into a right-justified word, then zero/sign-extends it. Sits between the memory byte
//  port and the datapath operand buses.
// PARAMETERS
//  BYTE_W        8   bits per incoming byte
//  NBYTES        4   lanes (>=2); localparam WIDTH = BYTE_W*NBYTES, CNT_W = $clog2(NBYTES+1)
//  LITTLE_ENDIAN 1   1: first burst byte -> lane 0; 0: first byte -> lane Len-1
// PORTS
//  Clock   in  1       rising-edge clock
//  Reset   in  1       asynchronous, active-low reset
//  I       in  BYTE_W  byte input (direct modes and burst)
//  E       in  1       enable for direct modes
//  FunSel  in  3       direct-mode select
//  Start   in  1       begin burst (sampled in IDLE only)
//  Len     in  CNT_W   burst byte count, legal 1..NBYTES
//  Valid   in  1       burst byte on I is valid
//  Ready   out 1       block accepts burst byte this cycle
//  Busy    out 1       state != IDLE
//  Done    out 1       registered one-cycle pulse: burst result on DROut
//  Err     out 1       registered one-cycle pulse: Start with illegal Len
//  DROut   out WIDTH   register contents
// BEHAVIOUR
//  Reset low: DROut=0, state=IDLE, Ready=Busy=Done=Err=0, counters 0; applies immediately, aborts any burst.
//  FSM: IDLE -> COLLECT (Start, legal Len) -> EXTEND (last byte accepted) -> IDLE.
//  IDLE priority: Start > E. Start with Len=0 or Len>NBYTES: Err=1 next cycle, DROut unchanged, stay IDLE.
//  Start legal: DROut<=0, cnt<=0, len latched; Ready=1 from next cycle.
//  Direct modes (IDLE, E=1, Start=0), one-cycle latency:
//   000 DROut <= sign-extend(I)          001 DROut <= zero-extend(I)
//   010 DROut <= {DROut[WIDTH-BYTE_W-1:0], I}   011 DROut <= {I, DROut[WIDTH-1:BYTE_W]}
//   100 DROut <= 0                        101..111 hold
//  COLLECT: Ready=1 (combinational on state). Valid&&Ready: lane (LE ? cnt : len-1-cnt) <= I, cnt++.
//   Valid low: hold, no timeout. E, FunSel, Start ignored. Gaps between bytes allowed.
//   Accept with cnt==len-1: -> EXTEND; Ready=0 in EXTEND.
//  EXTEND: lanes >= len filled per CONFIGURATION; -> IDLE; Done=1 the following cycle (DROut final).
//   Latency: Done high 2 clocks after last-byte accept edge's cycle; Start in that Done cycle is honoured.
//  Len==NBYTES: no lanes to extend; EXTEND still takes one cycle (fixed latency).
//  Arithmetic: cnt, len CNT_W bits unsigned; no wrap possible since len<=NBYTES.
// CONFIGURATION
//  BYTE_ASM_SEXT_EN defined: EXTEND fills lanes >= len with MSB of lane len-1 (sign-extend).
//  Undefined: lanes >= len stay 0 (zero-extend, already cleared at Start). Direct modes unaffected.
// STRUCTURE
//  Package byte_asm_pkg: state enum (IDLE, COLLECT, EXTEND), FunSel localparams FS_SEXT..FS_CLR,
//   function clog2p1 for CNT_W.
//  Sub-module byte_lane_sel: combinational cnt/len/LITTLE_ENDIAN -> one-hot lane write enable.
//  Top: FSM, counters, DROut register, extension mux, Done/Err flops.
// TESTING (defaults, BYTE_W=8 NBYTES=4)
//  Direct: E=1 FunSel=000 I=8'h9C -> DROut=32'hFFFFFF9C; FunSel=001 I=8'h9C -> 32'h0000009C.
//  Shift: DROut=32'h11223344, FunSel=010 I=8'hAA -> 32'h223344AA; then 011 I=8'h55 -> 32'h55223344.
//  Burst LE Len=4 bytes 01,02,03,04 with one Valid gap -> DROut=32'h04030201, Done 1 cycle, Busy low after.
//  Burst LE Len=2 bytes 34,F2 -> 32'hFFFFF234 with BYTE_ASM_SEXT_EN, 32'h0000F234 without.
//  Start Len=0 and Len=5 -> Err pulse, DROut unchanged, Busy=0; E pulses during COLLECT have no effect.
//  Reset low after 2 of 4 burst bytes -> DROut=0, Busy=0, Ready=0 immediately; next legal burst works.

Source files
------------

// File: rtl/byte_assembly_register_pkg.sv
// Shared types for the byte assembly register: FSM states, direct-mode selects,
// and the counter-width helper.
package byte_asm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EXTEND  = 2'd2
    } state_t;

    localparam logic [2:0] FS_SEXT = 3'b000;
    localparam logic [2:0] FS_ZEXT = 3'b001;
    localparam logic [2:0] FS_SHL  = 3'b010;
    localparam logic [2:0] FS_SHR  = 3'b011;
    localparam logic [2:0] FS_CLR  = 3'b100;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// Purpose: maps burst byte index to a one-hot lane write enable.
// Latency: combinational.
// Backpressure: none; gated by the caller's accept strobe.
module byte_lane_sel #(
    parameter int NBYTES        = 4,
    parameter int CNT_W         = 3,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic [CNT_W-1:0]  cnt,
    input  logic [CNT_W-1:0]  len,
    output logic [NBYTES-1:0] lane_we
);

    logic [CNT_W-1:0] lane;

    always_comb begin
        lane    = LITTLE_ENDIAN ? cnt : (len - cnt - CNT_W'(1));
        lane_we = '0;
        for (int i = 0; i < NBYTES; i++) begin
            lane_we[i] = (lane == CNT_W'(i));
        end
    end

endmodule

// File: rtl/byte_assembly_register.sv
// Purpose: byte-wide data register with direct load/shift modes and a handshaked burst assembler.
// Latency: direct modes 1 cycle; Done 2 cycles after the last burst byte is accepted.
// Backpressure: Ready high only in COLLECT; BYTE_ASM_SEXT_EN selects sign- over zero-extension.
module byte_assembly_register
    import byte_asm_pkg::*;
#(
    parameter int  BYTE_W        = 8,
    parameter int  NBYTES        = 4,
    parameter bit  LITTLE_ENDIAN = 1'b1,
    localparam int WIDTH         = BYTE_W * NBYTES,
    localparam int CNT_W         = clog2p1(NBYTES)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [BYTE_W-1:0] I,
    input  logic              E,
    input  logic [2:0]        FunSel,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Len,
    input  logic              Valid,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [WIDTH-1:0]  DROut
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, len;
    logic [NBYTES-1:0] lane_we;
    logic              len_ok;
    logic              accept;
    logic              last_byte;

    assign len_ok    = (Len != '0) && (Len <= CNT_W'(NBYTES));
    assign accept    = (state == COLLECT) && Valid;
    assign last_byte = (cnt == len - CNT_W'(1));
    assign Ready     = (state == COLLECT);
    assign Busy      = (state != IDLE);

    byte_lane_sel #(
        .NBYTES        (NBYTES),
        .CNT_W         (CNT_W),
        .LITTLE_ENDIAN (LITTLE_ENDIAN)
    ) u_lane_sel (
        .cnt     (cnt),
        .len     (len),
        .lane_we (lane_we)
    );

`ifdef BYTE_ASM_SEXT_EN
    logic             sign_bit;
    logic [WIDTH-1:0] ext_val;

    // Lanes at or above len replicate the top bit of the most significant collected lane.
    always_comb begin
        sign_bit = 1'b0;
        ext_val  = DROut;
        for (int i = 0; i < NBYTES; i++) begin
            if (CNT_W'(i) == len - CNT_W'(1)) sign_bit = DROut[i*BYTE_W + BYTE_W - 1];
        end
        for (int i = 0; i < NBYTES; i++) begin
            if (CNT_W'(i) >= len) ext_val[i*BYTE_W +: BYTE_W] = {BYTE_W{sign_bit}};
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start && len_ok) state_nxt = COLLECT;
            COLLECT: if (accept && last_byte) state_nxt = EXTEND;
            EXTEND:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            DROut <= '0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= (state == EXTEND);
            Err   <= (state == IDLE) && Start && !len_ok;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (len_ok) begin
                            DROut <= '0;
                            cnt   <= '0;
                            len   <= Len;
                        end
                    end else if (E) begin
                        case (FunSel)
                            FS_SEXT: DROut <= {{(WIDTH-BYTE_W){I[BYTE_W-1]}}, I};
                            FS_ZEXT: DROut <= {{(WIDTH-BYTE_W){1'b0}}, I};
                            FS_SHL:  DROut <= {DROut[WIDTH-BYTE_W-1:0], I};
                            FS_SHR:  DROut <= {I, DROut[WIDTH-1:BYTE_W]};
                            FS_CLR:  DROut <= '0;
                            default: ;
                        endcase
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (lane_we[i]) DROut[i*BYTE_W +: BYTE_W] <= I;
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EXTEND: begin
`ifdef BYTE_ASM_SEXT_EN
                    DROut <= ext_val;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_assembly_register.sv
// Randomized and directed bench for byte_assembly_register with a word-level reference model.
module tb_byte_assembly_register;

    localparam bit LE = 1'b1;

    logic        Clock  = 1'b0;
    logic        Reset  = 1'b0;
    logic [7:0]  I      = '0;
    logic        E      = 1'b0;
    logic [2:0]  FunSel = '0;
    logic        Start  = 1'b0;
    logic [2:0]  Len    = '0;
    logic        Valid  = 1'b0;
    logic        Ready, Busy, Done, Err;
    logic [31:0] DROut;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_dr   = '0;

    byte_assembly_register #(
        .BYTE_W        (8),
        .NBYTES        (4),
        .LITTLE_ENDIAN (LE)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .E      (E),
        .FunSel (FunSel),
        .Start  (Start),
        .Len    (Len),
        .Valid  (Valid),
        .Ready  (Ready),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .DROut  (DROut)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Word-level view of the direct modes.
    function automatic logic [31:0] direct_model(input logic [2:0] fs, input logic [7:0] b,
                                                 input logic [31:0] cur);
        case (fs)
            3'd0:    return (b >= 8'd128) ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
            3'd1:    return 32'(b);
            3'd2:    return (cur << 8) | 32'(b);
            3'd3:    return (cur >> 8) | (32'(b) << 24);
            3'd4:    return 32'd0;
            default: return cur;
        endcase
    endfunction

    function automatic logic [31:0] burst_model(input int len, input logic [7:0] bytes [4]);
        logic [31:0] w;
        int          lane;
        w = 32'd0;
        for (int k = 0; k < len; k++) begin
            lane = LE ? k : (len - 1 - k);
            w = w | (32'(bytes[k]) << (8 * lane));
        end
`ifdef BYTE_ASM_SEXT_EN
        if (len < 4 && w[8*len-1]) w = w | ~((32'd1 << (8 * len)) - 32'd1);
`endif
        return w;
    endfunction

    task automatic direct(input logic [2:0] fs, input logic [7:0] b, input string tag);
        E = 1'b1; FunSel = fs; I = b;
        exp_dr = direct_model(fs, b, exp_dr);
        tick();
        E = 1'b0;
        chk(tag, DROut, exp_dr);
    endtask

    // Ends in the Done cycle so a following Start lands on it.
    task automatic burst(input int len, input logic [7:0] bytes [4], input logic [3:0] gaps,
                         input string tag);
        logic [31:0] w;
        w = burst_model(len, bytes);
        Start = 1'b1; Len = 3'(len);
        tick();
        Start = 1'b0;
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_ready"}, 32'(Ready), 32'd1);
        chk({tag, "_done_low"}, 32'(Done), 32'd0);
        chk({tag, "_cleared"}, DROut, 32'd0);
        for (int k = 0; k < len; k++) begin
            if (gaps[k]) begin
                Valid = 1'b0; E = 1'b1; FunSel = 3'($urandom_range(0, 4)); I = 8'($urandom);
                Start = 1'b1; Len = 3'd1;
                tick();
                E = 1'b0; Start = 1'b0;
                chk({tag, "_gap_ready"}, 32'(Ready), 32'd1);
            end
            Valid = 1'b1; I = bytes[k];
            tick();
            Valid = 1'b0;
        end
        chk({tag, "_ext_ready"}, 32'(Ready), 32'd0);
        chk({tag, "_ext_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_ext_done"}, 32'(Done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_idle"}, 32'(Busy), 32'd0);
        chk({tag, "_word"}, DROut, w);
        exp_dr = w;
    endtask

    task automatic bad_start(input logic [2:0] l, input string tag);
        Start = 1'b1; Len = l;
        tick();
        Start = 1'b0;
        chk({tag, "_err"}, 32'(Err), 32'd1);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_hold"}, DROut, exp_dr);
        tick();
        chk({tag, "_err_clear"}, 32'(Err), 32'd0);
    endtask

    initial begin
        logic [7:0] bytes [4];
        int         len;

        #2;
        chk("rst_drout", DROut, 32'd0);
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        tick();
        Reset = 1'b1;
        tick();

        direct(3'b000, 8'h9C, "sext_9c");
        chk("sext_9c_const", DROut, 32'hFFFF_FF9C);
        direct(3'b001, 8'h9C, "zext_9c");
        chk("zext_9c_const", DROut, 32'h0000_009C);
        direct(3'b001, 8'h11, "load_11");
        direct(3'b010, 8'h22, "shl_22");
        direct(3'b010, 8'h33, "shl_33");
        direct(3'b010, 8'h44, "shl_44");
        chk("preload_const", DROut, 32'h1122_3344);
        direct(3'b010, 8'hAA, "shl_aa");
        chk("shl_aa_const", DROut, 32'h2233_44AA);
        direct(3'b011, 8'h55, "shr_55");
        chk("shr_55_const", DROut, 32'h5522_3344);

        // E low must hold the register whatever FunSel says.
        FunSel = 3'b100; I = 8'hFF;
        tick();
        chk("e_low_hold", DROut, exp_dr);

        for (int n = 0; n < 24; n++) begin
            direct(3'($urandom_range(0, 7)), 8'($urandom), "rand_direct");
        end

        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
        burst(4, bytes, 4'b0100, "le4");
        chk("le4_const", DROut, 32'h0403_0201);
        tick();
        chk("le4_done_pulse", 32'(Done), 32'd0);

        bytes[0] = 8'h34; bytes[1] = 8'hF2;
`ifdef BYTE_ASM_SEXT_EN
        burst(2, bytes, 4'b0000, "le2");
        chk("le2_const", DROut, 32'hFFFF_F234);
`else
        burst(2, bytes, 4'b0000, "le2");
        chk("le2_const", DROut, 32'h0000_F234);
`endif

        // Back-to-back: each burst starts in the previous Done cycle.
        for (int n = 0; n < 10; n++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
            burst(len, bytes, 4'($urandom), "rand_burst");
        end
        tick();

        bad_start(3'd0, "len0");
        bad_start(3'd5, "len5");
        bad_start(3'd7, "len7");

        // Reset in the middle of a burst takes effect without a clock edge.
        Start = 1'b1; Len = 3'd4;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            Valid = 1'b1; I = 8'hA0 + 8'(k);
            tick();
        end
        Valid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("midrst_drout", DROut, 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_ready", 32'(Ready), 32'd0);
        exp_dr = 32'd0;
        tick();
        Reset = 1'b1;
        tick();
        bytes[0] = 8'h81; bytes[1] = 8'h7E; bytes[2] = 8'hC3;
        burst(3, bytes, 4'b0010, "post_rst");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
